// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: streams bitstream words MSB-first into a configuration chain, with optional readback verify
module ccff_chain_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              verify,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              prog_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              mismatch,
  output logic [CNT_W-1:0]  mismatch_cnt
);
  localparam int RW = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LEN = CNT_W'(CHAIN_LEN);
  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;
  state_t            state_q, state_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [RW-1:0]     rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, left, mcnt_q;
  logic              ver_q, head_q, en_q, busy_q, done_q, mis_q;
  logic              active, emit, pass_end, start_ok, take, miss;
  // A pass ends the cycle after its last bit is registered, so that bit's enable is still seen inside the pass state
  always_comb begin
    active     = state_q == LOAD || state_q == VERIFY;
    emit       = active && rem_q != '0;
    pass_end   = active && cnt_q == LEN;
    start_ok   = state_q == IDLE && start;
    state_d    = start_ok ? LOAD :
                 state_q == DONE ? IDLE :
                 !pass_end ? state_q :
                 (state_q == LOAD && ver_q) ? VERIFY : DONE;
    cnt_d      = (pass_end || !active) ? '0 : cnt_q + CNT_W'(emit);
    left       = LEN - cnt_d;
    word_ready = active && state_d != DONE && left != '0 && (rem_q == '0 || (rem_q == RW'(1) && emit));
    take       = word_ready && word_valid;
    rem_d      = take ? (left >= CNT_W'(WORD_W) ? RW'(WORD_W) : RW'(left)) : rem_q - RW'(emit);
    sr_d       = take ? word_data : emit ? sr_q << 1 : sr_q;
    miss       = state_q == VERIFY && en_q && ccff_tail != head_q;
  end
  // Sequencer, shifter and registered outputs
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      ver_q   <= 1'b0;
      head_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      ver_q   <= start_ok ? verify : ver_q;
      head_q  <= emit ? sr_q[WORD_W-1] : head_q;
      en_q    <= emit;
      busy_q  <= state_d != IDLE;
      done_q  <= state_d == DONE;
      mis_q   <= start_ok ? 1'b0 : mis_q | miss;
      mcnt_q  <= start_ok ? '0 : (miss && mcnt_q != '1) ? mcnt_q + 1'b1 : mcnt_q;
    end
  end
  assign ccff_head    = head_q;
  assign prog_clk_en  = en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign mismatch     = mis_q;
  assign mismatch_cnt = mcnt_q;
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: randomized checks of the chain loader against a bit-list model and a behavioural chain
module tb_ccff_chain_loader;
  localparam int W = 32, L = 40, CW = 16, NW = (L + W - 1) / W;
  typedef logic [W-1:0] wv_t [NW];
  logic clk = 0, prog_reset = 1, start = 0, verify = 0, word_valid = 0;
  logic [W-1:0] word_data = '0;
  logic word_ready, ccff_head, prog_clk_en, ccff_tail, busy, done, mismatch;
  logic [CW-1:0] mismatch_cnt;
  logic [L-1:0] chain = '0, obs = '0;
  logic [W-1:0] src[$];
  int errors = 0, checks = 0, cyc = 0;
  int en_cnt, done_cnt, bad_en, head_move, first_en, last_en, done_cyc;
  logic prev_head = 0, mis_done, busy_after;
  logic [CW-1:0] mcnt_done;
  logic [2:0] start_snap;
  logic [6:0] rst_snap;
  always #5 clk = ~clk;
  ccff_chain_loader #(.WORD_W(W), .CHAIN_LEN(L), .CNT_W(CW)) dut (
    .prog_clk(clk), .prog_reset(prog_reset), .start(start), .verify(verify),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .ccff_head(ccff_head), .prog_clk_en(prog_clk_en), .ccff_tail(ccff_tail),
    .busy(busy), .done(done), .mismatch(mismatch), .mismatch_cnt(mismatch_cnt));
  // Behavioural chain: first flop chain[0], last flop chain[L-1]
  assign ccff_tail = chain[L-1];
  always @(posedge clk) if (prog_clk_en) chain <= {chain[L-2:0], ccff_head};
  always @(negedge clk) begin
    cyc++;
    if (prog_clk_en) begin
      obs = {obs[L-2:0], ccff_head};
      en_cnt++;
      if (first_en < 0) first_en = cyc;
      last_en = cyc;
      if (done || !busy) bad_en++;
    end else if (ccff_head !== prev_head) head_move++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      mis_done = mismatch;
      mcnt_done = mismatch_cnt;
    end
    prev_head = ccff_head;
  end
  // Expected pass content: the first L bits of the pass's words, each word MSB first
  function automatic logic [L-1:0] frame(input wv_t w);
    logic [L-1:0] r;
    for (int i = 0; i < L; i++) r[L-1-i] = w[i/W][W-1-(i%W)];
    return r;
  endfunction
  function automatic wv_t rand_words();
    wv_t w;
    for (int i = 0; i < NW; i++) w[i] = $urandom;
    return w;
  endfunction
  task automatic push(input wv_t w);
    for (int i = 0; i < NW; i++) src.push_back(w[i]);
  endtask
  // mode: 0 valid held, 1 valid toggling, 2 valid random; poke re-pulses start mid-pass; rst_at>0 resets after that many bits
  task automatic run(input bit ver, input int mode, input bit poke, input int rst_at, output bit to);
    bit ph = 1, hs;
    int c = 0, ne = 0;
    en_cnt = 0; done_cnt = 0; bad_en = 0; head_move = 0; first_en = -1; last_en = -1; done_cyc = -1;
    @(negedge clk);
    start = 1; verify = ver;
    @(negedge clk);
    start = 0; verify = 0;
    start_snap = {busy, mismatch, mismatch_cnt != '0};
    to = 1;
    while (c < 400) begin
      ne += int'(prog_clk_en);
      if (done) begin to = 0; break; end
      if (rst_at > 0 && ne == rst_at) begin
        prog_reset = 1; word_valid = 0;
        @(negedge clk);
        prog_reset = 0;
        rst_snap = {word_ready, ccff_head, prog_clk_en, busy, done, mismatch, mismatch_cnt != '0};
        to = 0;
        break;
      end
      word_valid = src.size() > 0 && (mode == 0 || (mode == 1 && ph) || (mode == 2 && $urandom_range(0, 1) == 1));
      word_data = word_valid ? src[0] : '0;
      ph = !ph;
      start = poke && c == 10;
      verify = poke && c == 10;
      #1 hs = word_valid && word_ready;
      @(negedge clk);
      if (hs) void'(src.pop_front());
      c++;
    end
    word_valid = 0; start = 0; verify = 0;
    @(negedge clk);
    busy_after = busy;
    @(negedge clk);
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if ({word_ready, ccff_head, prog_clk_en, busy, done, mismatch} !== 6'b0) begin errors++; $display("FAIL reset_outputs: got %b want 000000", {word_ready, ccff_head, prog_clk_en, busy, done, mismatch}); end
    checks++; if (mismatch_cnt !== '0) begin errors++; $display("FAIL reset_mcnt: got %0d want 0", mismatch_cnt); end
    prog_reset = 0;
    repeat (2) @(negedge clk);
    checks++; if ({word_ready, busy, prog_clk_en} !== 3'b0) begin errors++; $display("FAIL idle_after_reset: got %b want 000", {word_ready, busy, prog_clk_en}); end
  endtask
  task automatic test_basic();
    wv_t w;
    bit to;
    for (int k = 0; k < 3; k++) begin
      w = rand_words();
      push(w);
      run(0, 0, 0, 0, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout: got %b want 0", to); end
      checks++; if (obs !== frame(w)) begin errors++; $display("FAIL basic_bits: got %h want %h", obs, frame(w)); end
      checks++; if (en_cnt !== L) begin errors++; $display("FAIL basic_en_count: got %0d want %0d", en_cnt, L); end
      checks++; if (last_en - first_en !== L - 1) begin errors++; $display("FAIL basic_back_to_back: got span %0d want %0d", last_en - first_en, L - 1); end
      checks++; if (done_cyc !== last_en + 1) begin errors++; $display("FAIL basic_done_timing: got %0d want %0d", done_cyc, last_en + 1); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt); end
      checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL basic_busy_after_done: got %b want 0", busy_after); end
      checks++; if (start_snap !== 3'b100) begin errors++; $display("FAIL basic_busy_after_start: got %b want 100", start_snap); end
      checks++; if (src.size() !== 0) begin errors++; $display("FAIL basic_words_taken: got %0d left want 0", src.size()); end
      checks++; if (bad_en !== 0) begin errors++; $display("FAIL basic_en_outside_pass: got %0d want 0", bad_en); end
    end
  endtask
  task automatic test_framing();
    wv_t w = '{32'hA5A5A5A5, 32'hFF000000};
    bit to;
    push(w);
    run(0, 0, 0, 0, to);
    checks++; if (obs !== 40'hA5A5A5A5FF) begin errors++; $display("FAIL framing_bits: got %h want a5a5a5a5ff", obs); end
    checks++; if (chain !== 40'hA5A5A5A5FF) begin errors++; $display("FAIL framing_chain: got %h want a5a5a5a5ff", chain); end
    checks++; if (en_cnt !== L) begin errors++; $display("FAIL framing_en_count: got %0d want %0d", en_cnt, L); end
    checks++; if (src.size() !== 0) begin errors++; $display("FAIL framing_words_taken: got %0d left want 0", src.size()); end
  endtask
  task automatic test_stall();
    wv_t w = '{32'hA5A5A5A5, 32'hFF000000}, w2;
    bit to;
    push(w);
    run(0, 1, 0, 0, to);
    checks++; if (chain !== 40'hA5A5A5A5FF) begin errors++; $display("FAIL stall_toggle_chain: got %h want a5a5a5a5ff", chain); end
    checks++; if (head_move !== 0) begin errors++; $display("FAIL stall_toggle_head: got %0d moves want 0", head_move); end
    checks++; if (en_cnt !== L) begin errors++; $display("FAIL stall_toggle_en: got %0d want %0d", en_cnt, L); end
    for (int k = 0; k < 3; k++) begin
      w2 = rand_words();
      push(w2); push(w2);
      run(1, 2, 0, 0, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL stall_rand_timeout: got %b want 0", to); end
      checks++; if (chain !== frame(w2)) begin errors++; $display("FAIL stall_rand_chain: got %h want %h", chain, frame(w2)); end
      checks++; if (head_move !== 0 || mis_done !== 1'b0) begin errors++; $display("FAIL stall_rand_head: got moves=%0d mis=%b want 0 0", head_move, mis_done); end
    end
  endtask
  task automatic test_verify();
    wv_t a, b;
    bit to;
    int exp_n;
    a = rand_words();
    push(a); push(a);
    run(1, 0, 0, 0, to);
    checks++; if (en_cnt !== 2 * L) begin errors++; $display("FAIL verify_ok_en: got %0d want %0d", en_cnt, 2 * L); end
    checks++; if ({mis_done, mcnt_done} !== '0) begin errors++; $display("FAIL verify_ok_result: got mis=%b cnt=%0d want 0 0", mis_done, mcnt_done); end
    b = a; b[0][W-1-5] = ~b[0][W-1-5];
    push(a); push(b);
    run(1, 0, 0, 0, to);
    checks++; if ({mis_done, mcnt_done} !== {1'b1, 16'd1}) begin errors++; $display("FAIL verify_bit5: got mis=%b cnt=%0d want 1 1", mis_done, mcnt_done); end
    push(a);
    run(0, 0, 0, 0, to);
    checks++; if (start_snap !== 3'b100) begin errors++; $display("FAIL verify_clear_on_start: got %b want 100", start_snap); end
    checks++; if ({mis_done, mcnt_done} !== '0) begin errors++; $display("FAIL verify_clear_at_done: got mis=%b cnt=%0d want 0 0", mis_done, mcnt_done); end
    for (int k = 0; k < 4; k++) begin
      a = rand_words();
      b = a;
      for (int j = 0; j < k * 3; j++) b[$urandom_range(0, NW-1)][$urandom_range(0, W-1)] ^= 1'b1;
      exp_n = $countones(frame(a) ^ frame(b));
      push(a); push(b);
      run(1, 2, 0, 0, to);
      checks++; if (mcnt_done !== CW'(exp_n) || mis_done !== (exp_n != 0)) begin errors++; $display("FAIL verify_rand: got mis=%b cnt=%0d want %b %0d", mis_done, mcnt_done, exp_n != 0, exp_n); end
    end
  endtask
  task automatic test_busy_start();
    wv_t w = rand_words();
    bit to;
    push(w);
    run(0, 0, 1, 0, to);
    checks++; if (en_cnt !== L || done_cnt !== 1) begin errors++; $display("FAIL busy_start_ignored: got en=%0d done=%0d want %0d 1", en_cnt, done_cnt, L); end
    checks++; if (obs !== frame(w)) begin errors++; $display("FAIL busy_start_bits: got %h want %h", obs, frame(w)); end
  endtask
  task automatic test_reset_mid();
    wv_t w = rand_words();
    bit to;
    push(w);
    run(0, 0, 0, 17, to);
    checks++; if (rst_snap !== '0) begin errors++; $display("FAIL reset_mid_outputs: got %b want 0000000", rst_snap); end
    repeat (4) @(negedge clk);
    checks++; if (done_cnt !== 0 || busy !== 1'b0) begin errors++; $display("FAIL reset_mid_no_done: got done=%0d busy=%b want 0 0", done_cnt, busy); end
    src.delete();
    w = rand_words();
    push(w);
    run(0, 0, 0, 0, to);
    checks++; if (obs !== frame(w) || done_cnt !== 1 || en_cnt !== L) begin errors++; $display("FAIL reset_mid_reload: got %h done=%0d en=%0d want %h 1 %0d", obs, done_cnt, en_cnt, frame(w), L); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_framing();
    test_stall();
    test_verify();
    test_busy_start();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
